// File: rtl/keccak_gather.sv
// Gathers sixteen 32-bit custom-instruction writes into one 512-bit block and
// offers the block to keccak_ctrl over a valid/ready handshake.
module keccak_gather #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        wr_en,
  input  logic [5:0]                  num,
  input  logic [WORD_W-1:0]           in32,
  input  logic                        flush,
  input  logic                        clr,
  output logic [WORD_W*NUM_WORDS-1:0] out512,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WORDS-1:0]        word_mask,
  output logic                        busy,
  output logic                        ovf_err
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic [WORD_W*NUM_WORDS-1:0]   data_q, data_d;
  logic [NUM_WORDS-1:0]          mask_q, mask_d;
  logic [3:0]                    ptr_q, ptr_d;
  logic                          ovf_q, ovf_d;
  logic [3:0]                    idx;
  logic                          wr_fire;

  assign wr_fire = en & wr_en;
  assign idx     = num[5] ? ptr_q : num[3:0];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = FILL;
      data_d  = '0;
      mask_d  = '0;
      ptr_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == FILL) begin
      if (wr_fire) begin
        for (int k = 0; k < NUM_WORDS; k++) begin
          if (idx == 4'(k)) begin
            data_d[k*WORD_W +: WORD_W] = in32;
            mask_d[k]                  = 1'b1;
          end
        end
        if (num[5]) ptr_d = ptr_q + 4'd1;
      end
      // Block closes on the post-write mask so a same-cycle write+flush is kept.
      if ((&mask_d) || (en && flush && (|mask_d))) state_d = HOLD;
    end else begin
      if (en && (wr_en || flush)) ovf_d = 1'b1;
      if (out_ready) begin
        state_d = FILL;
        data_d  = '0;
        mask_d  = '0;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      data_q  <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out512    = data_q;
  assign word_mask = mask_q;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == HOLD);
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_keccak_gather.sv
// Self-checking bench for keccak_gather: directed table, hand sequences and
// randomized traffic against a word-array reference model.
module tb_keccak_gather;

  logic         clk = 1'b0;
  logic         rst, en, wr_en, flush, clr, out_ready;
  logic [5:0]   num;
  logic [31:0]  in32;
  logic [511:0] out512;
  logic         out_valid, busy, ovf_err;
  logic [15:0]  word_mask;

  int nvec  = 0;
  int nfail = 0;

  keccak_gather dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .num(num), .in32(in32),
    .flush(flush), .clr(clr), .out512(out512), .out_valid(out_valid),
    .out_ready(out_ready), .word_mask(word_mask), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Reference model: block as an array of words plus a written flag per word.
  logic [31:0] m_w  [16];
  bit          m_wr [16];
  int          m_ptr;
  bit          m_hold, m_ovf;

  function automatic void m_clear_block();
    for (int i = 0; i < 16; i++) begin
      m_w[i]  = '0;
      m_wr[i] = 1'b0;
    end
    m_ptr = 0;
  endfunction

  function automatic void model_step();
    int idx, cnt;
    if (rst || clr) begin
      m_clear_block();
      m_hold = 1'b0;
      m_ovf  = 1'b0;
    end else if (!m_hold) begin
      if (en && wr_en) begin
        idx = num[5] ? m_ptr : int'(num[3:0]);
        m_w[idx]  = in32;
        m_wr[idx] = 1'b1;
        if (num[5]) m_ptr = (m_ptr + 1) % 16;
      end
      cnt = 0;
      for (int i = 0; i < 16; i++) cnt += m_wr[i] ? 1 : 0;
      if (cnt == 16 || (en && flush && cnt > 0)) m_hold = 1'b1;
    end else begin
      if (en && (wr_en || flush)) m_ovf = 1'b1;
      if (out_ready) begin
        m_clear_block();
        m_hold = 1'b0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [511:0] eb;
    logic [15:0]  em;
    for (int i = 0; i < 16; i++) begin
      eb[i*32 +: 32] = m_w[i];
      em[i]          = m_wr[i];
    end
    check("out512", out512, eb);
    check("word_mask", {496'b0, word_mask}, {496'b0, em});
    check("out_valid", {511'b0, out_valid}, {511'b0, m_hold});
    check("busy", {511'b0, busy}, {511'b0, m_hold});
    check("ovf_err", {511'b0, ovf_err}, {511'b0, m_ovf});
  endtask

  // One clock: drive inputs, advance model with them, compare after the edge.
  task automatic cyc(input logic e, input logic w, input logic [5:0] n, input logic [31:0] d,
                     input logic f, input logic c, input logic r, input logic rs);
    en = e; wr_en = w; num = n; in32 = d; flush = f; clr = c; out_ready = r; rst = rs;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        e, w;
    logic [5:0]  n;
    logic [31:0] d;
    logic        f, c, r;
    logic        exp_valid;
    logic [15:0] exp_mask;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1, 0, 6'd0,  32'h0,        0, 1, 0, 0, 16'h0000, 0};
    tbl[1]  = '{1, 1, 6'd3,  32'hDEADBEEF, 0, 0, 0, 0, 16'h0008, 0};
    tbl[2]  = '{1, 1, 6'd15, 32'hCAFEF00D, 0, 0, 0, 0, 16'h8008, 0};
    tbl[3]  = '{1, 0, 6'd0,  32'h0,        1, 0, 0, 1, 16'h8008, 0};
    tbl[4]  = '{1, 0, 6'd0,  32'h0,        0, 0, 1, 0, 16'h0000, 0};
    tbl[5]  = '{1, 0, 6'd0,  32'h0,        1, 0, 0, 0, 16'h0000, 0};
    tbl[6]  = '{1, 1, 6'd7,  32'hA5A5A5A5, 1, 0, 0, 1, 16'h0080, 0};
    tbl[7]  = '{1, 0, 6'd0,  32'h0,        0, 0, 0, 1, 16'h0080, 0};
    tbl[8]  = '{1, 0, 6'd0,  32'h0,        0, 0, 1, 0, 16'h0000, 0};
    tbl[9]  = '{1, 1, 6'd5,  32'h11111111, 0, 0, 1, 0, 16'h0020, 0};
    tbl[10] = '{1, 1, 6'd5,  32'h22222222, 0, 0, 0, 0, 16'h0020, 0};
    tbl[11] = '{0, 1, 6'd6,  32'h66666666, 1, 0, 0, 0, 16'h0020, 0};
    tbl[12] = '{1, 0, 6'd0,  32'h0,        0, 1, 0, 0, 16'h0000, 0};
    tbl[13] = '{1, 1, 6'h20, 32'h77777777, 0, 0, 0, 0, 16'h0001, 0};

    en = 0; wr_en = 0; num = 0; in32 = 0; flush = 0; clr = 0; out_ready = 0; rst = 1;
    m_hold = 0; m_ovf = 0; m_clear_block();

    // Reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check("rst out512", out512, 512'b0);
    check("rst flags", {508'b0, out_valid, busy, ovf_err, |word_mask}, 512'b0);

    // Sequence 1: 16 auto writes, hold, overflow attempt, handshake, clr
    for (int i = 0; i < 16; i++) begin
      check("valid before last", {511'b0, out_valid}, 512'b0);
      cyc(1, 1, 6'b100000, 32'(i), 0, 0, 0, 0);
    end
    check("full valid", {511'b0, out_valid}, 512'b1);
    check("full word0", {480'b0, out512[31:0]}, 512'h0);
    check("full word15", {480'b0, out512[511:480]}, 512'hF);
    check("full mask", {496'b0, word_mask}, 512'hFFFF);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("hold valid", {511'b0, out_valid}, 512'b1);
    cyc(1, 1, 6'd0, 32'h12345678, 0, 0, 0, 0);
    check("ovf word0", {480'b0, out512[31:0]}, 512'h0);
    check("ovf set", {511'b0, ovf_err}, 512'b1);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    check("xfer valid", {511'b0, out_valid}, 512'b0);
    check("xfer out", out512, 512'b0);
    check("ovf sticky", {511'b0, ovf_err}, 512'b1);
    cyc(1, 1, 6'b100000, 32'hABCD0001, 0, 0, 0, 0);
    check("post-xfer write", {480'b0, out512[31:0]}, 512'hABCD0001);

    // Directed table (explicit index, flush corners, clr mid-fill)
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].e, tbl[i].w, tbl[i].n, tbl[i].d, tbl[i].f, tbl[i].c, tbl[i].r, 0);
      check($sformatf("tbl%0d valid", i), {511'b0, out_valid}, {511'b0, tbl[i].exp_valid});
      check($sformatf("tbl%0d mask", i), {496'b0, word_mask}, {496'b0, tbl[i].exp_mask});
      check($sformatf("tbl%0d ovf", i), {511'b0, ovf_err}, {511'b0, tbl[i].exp_ovf});
      if (i == 3) begin
        check("flush w3", {480'b0, out512[127:96]}, {480'b0, 32'hDEADBEEF});
        check("flush w15", {480'b0, out512[511:480]}, {480'b0, 32'hCAFEF00D});
      end
      if (i == 11) begin
        check("rewrite w5", {480'b0, out512[191:160]}, {480'b0, 32'h22222222});
        check("en0 w6", {480'b0, out512[223:192]}, 512'b0);
      end
    end
    check("clr ptr word0", {480'b0, out512[31:0]}, {480'b0, 32'h77777777});

    // rst beats a simultaneous handshake
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 6'b100000, 32'hF0 + 32'(i), 0, 0, 0, 0);
    check("pre-rst valid", {511'b0, out_valid}, 512'b1);
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    check("rst xfer out", out512, 512'b0);
    check("rst xfer flags", {508'b0, out_valid, busy, ovf_err, |word_mask}, 512'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 9) != 0), $urandom_range(0, 1), 6'($urandom), $urandom,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
